// File: rtl/sample_sequencer_if.sv
// Sample sequencer bus: ADC-side inputs plus sequencing/status outputs.
// ovr_cnt exists only when SAMPLE_SEQ_OVR_COUNT_EN is defined.
interface sample_sequencer_if;
  logic        data_valid;
  logic [9:0]  data_in;
  logic        run;
  logic        clr_ovr;
  logic [9:0]  x_out;
  logic        proc_en;
  logic        dac_load;
  logic        busy;
  logic        overrun;
  logic [15:0] sample_cnt;
`ifdef SAMPLE_SEQ_OVR_COUNT_EN
  logic [7:0]  ovr_cnt;

  modport master (
    output data_valid, data_in, run, clr_ovr,
    input  x_out, proc_en, dac_load, busy,
    input  overrun, sample_cnt, ovr_cnt
  );
  modport slave (
    input  data_valid, data_in, run, clr_ovr,
    output x_out, proc_en, dac_load, busy,
    output overrun, sample_cnt, ovr_cnt
  );
`else
  modport master (
    output data_valid, data_in, run, clr_ovr,
    input  x_out, proc_en, dac_load, busy,
    input  overrun, sample_cnt
  );
  modport slave (
    input  data_valid, data_in, run, clr_ovr,
    output x_out, proc_en, dac_load, busy,
    output overrun, sample_cnt
  );
`endif
endinterface

// File: rtl/sample_sequencer.sv
// ADC sample sequencer: capture -> process -> DAC load, with overrun flag.
// Optional SAMPLE_SEQ_OVR_COUNT_EN adds a saturating dropped-edge counter.
module sample_sequencer #(
  parameter logic [9:0]  ADC_OFFSET   = 10'd512,
  parameter int unsigned PROC_LATENCY = 4
) (
  input logic               sysclk,
  input logic               reset,
  sample_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] PROCESS = 2'd2;
  localparam logic [1:0] OUTPUT  = 2'd3;

  localparam logic [3:0] LAT_INIT = 4'(PROC_LATENCY - 1);

  logic [1:0]  state;
  logic [3:0]  lat;
  logic        dv_q;
  logic        armed;
  logic        edge_ev;
  logic        drop;
  logic [9:0]  x_q;
  logic        proc_q;
  logic        dac_q;
  logic        ovr_q;
  logic [15:0] cnt_q;

  // armed stays low after reset until data_valid is seen low,
  // so a level already high at release is not taken as an edge
  assign edge_ev = bus.data_valid & ~dv_q & armed;
  assign drop    = edge_ev & (state != IDLE);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      lat    <= 4'd0;
      dv_q   <= 1'b0;
      armed  <= 1'b0;
      x_q    <= 10'd0;
      proc_q <= 1'b0;
      dac_q  <= 1'b0;
      ovr_q  <= 1'b0;
      cnt_q  <= 16'd0;
    end else begin
      dv_q   <= bus.data_valid;
      armed  <= armed | ~bus.data_valid;
      proc_q <= 1'b0;
      dac_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (edge_ev && bus.run) begin
            state  <= CAPTURE;
            x_q    <= bus.data_in - ADC_OFFSET;
            proc_q <= 1'b1;
          end
        end
        CAPTURE: begin
          state <= PROCESS;
          lat   <= LAT_INIT;
        end
        PROCESS: begin
          if (lat == 4'd0) begin
            state <= OUTPUT;
            dac_q <= 1'b1;
          end else begin
            lat <= lat - 4'd1;
          end
        end
        OUTPUT: begin
          state <= IDLE;
          cnt_q <= cnt_q + 16'd1;
        end
        default: state <= IDLE;
      endcase
      if (drop)
        ovr_q <= 1'b1;
      else if (bus.clr_ovr)
        ovr_q <= 1'b0;
    end
  end

  assign bus.x_out      = x_q;
  assign bus.proc_en    = proc_q;
  assign bus.dac_load   = dac_q;
  assign bus.busy       = (state != IDLE);
  assign bus.overrun    = ovr_q;
  assign bus.sample_cnt = cnt_q;

`ifdef SAMPLE_SEQ_OVR_COUNT_EN
  logic [7:0] oc_q;

  // a drop in the clearing cycle restarts the count at one
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)
      oc_q <= 8'd0;
    else if (drop)
      oc_q <= bus.clr_ovr ? 8'd1
            : (oc_q == 8'hFF) ? oc_q : oc_q + 8'd1;
    else if (bus.clr_ovr)
      oc_q <= 8'd0;
  end

  assign bus.ovr_cnt = oc_q;
`endif
endmodule

// File: tb/tb_sample_sequencer.sv
// Randomized self-checking bench for sample_sequencer against a
// timestamp-based behavioural model, plus directed literal checks.
module tb_sample_sequencer;
  localparam int         PL  = 4;
  localparam logic [9:0] OFF = 10'd512;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sample_sequencer_if bus ();

  sample_sequencer #(
    .ADC_OFFSET   (OFF),
    .PROC_LATENCY (PL)
  ) u_dut (
    .sysclk (clk),
    .reset  (rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: a sample accepted at posedge index s shows proc_en after s,
  // dac_load after s+PL+1, and retires (count++) at s+PL+2
  int          t;
  int          m_start;
  bit          m_prev;
  logic [9:0]  m_x;
  bit          m_ovr;
  logic [15:0] m_cnt;
  int          m_oc;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @t=%0d: got %0d want %0d", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t       = 0;
    m_start = -1;
    m_prev  = 1'b1;
    m_x     = 10'd0;
    m_ovr   = 1'b0;
    m_cnt   = 16'd0;
    m_oc    = 0;
  endtask

  task automatic model_update();
    bit ev;
    bit bsy;
    t++;
    ev     = bus.data_valid && !m_prev;
    m_prev = bus.data_valid;
    bsy    = (m_start >= 0);
    if (bsy && t == m_start + PL + 2) begin
      m_cnt   = m_cnt + 16'd1;
      m_start = -1;
    end
    if (bus.clr_ovr) begin
      m_ovr = 1'b0;
      m_oc  = 0;
    end
    if (ev && bsy) begin
      m_ovr = 1'b1;
      m_oc  = (m_oc >= 255) ? 255 : m_oc + 1;
    end else if (ev && bus.run) begin
      m_start = t;
      m_x     = bus.data_in - OFF;
    end
  endtask

  task automatic compare();
    bit act;
    act = (m_start >= 0);
    chk("x_out", 32'(bus.x_out), 32'(m_x));
    chk("proc_en", 32'(bus.proc_en), 32'(act && t == m_start));
    chk("dac_load", 32'(bus.dac_load), 32'(act && t == m_start + PL + 1));
    chk("busy", 32'(bus.busy), 32'(act));
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
    chk("sample_cnt", 32'(bus.sample_cnt), 32'(m_cnt));
`ifdef SAMPLE_SEQ_OVR_COUNT_EN
    chk("ovr_cnt", 32'(bus.ovr_cnt), 32'(m_oc));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic steps(input int n, output int pe_n, output int dl_n);
    pe_n = 0;
    dl_n = 0;
    for (int i = 0; i < n; i++) begin
      step();
      pe_n += int'(bus.proc_en);
      dl_n += int'(bus.dac_load);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_x_out", 32'(bus.x_out), 32'd0);
    chk("rst_proc_en", 32'(bus.proc_en), 32'd0);
    chk("rst_dac_load", 32'(bus.dac_load), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_sample_cnt", 32'(bus.sample_cnt), 32'd0);
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_sample(input logic [9:0] din, input int n,
                              output int pe_at, output int dl_at,
                              output int bz);
    pe_at = -1;
    dl_at = -1;
    bz    = 0;
    bus.data_in    = din;
    bus.data_valid = 1'b1;
    for (int i = 1; i <= n; i++) begin
      step();
      bus.data_valid = 1'b0;
      if (bus.proc_en) pe_at = i;
      if (bus.dac_load) dl_at = i;
      if (bus.busy) bz++;
    end
  endtask

  initial begin
    int pe_at, dl_at, bz, pe_n, dl_n;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.data_valid = 1'b0;
    bus.data_in    = 10'd0;
    bus.run        = 1'b0;
    bus.clr_ovr    = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // single sample, data_in = 700
    bus.run = 1'b1;
    step();
    pulse_sample(10'd700, 8, pe_at, dl_at, bz);
    chk("s1_x_out", 32'(bus.x_out), 32'd188);
    chk("s1_model_x", 32'(m_x), 32'd188);
    chk("s1_proc_at", 32'(pe_at), 32'd1);
    chk("s1_dac_at", 32'(dl_at), 32'd6);
    chk("s1_busy_len", 32'(bz), 32'd6);
    chk("s1_cnt", 32'(bus.sample_cnt), 32'd1);

    pulse_sample(10'd0, 8, pe_at, dl_at, bz);
    chk("x_zero", 32'(bus.x_out), 32'h200);
    pulse_sample(10'd512, 8, pe_at, dl_at, bz);
    chk("x_mid", 32'(bus.x_out), 32'd0);

    // second edge 3 cycles after the first is dropped
    bus.data_in    = 10'd100;
    bus.data_valid = 1'b1;
    steps(1, pe_n, dl_n);
    bz = dl_n;
    bus.data_valid = 1'b0;
    steps(2, pe_n, dl_n);
    bz += dl_n;
    bus.data_in    = 10'd999;
    bus.data_valid = 1'b1;
    steps(1, pe_n, dl_n);
    bz += dl_n;
    bus.data_valid = 1'b0;
    steps(6, pe_n, dl_n);
    bz += dl_n;
    chk("ovr_flag", 32'(bus.overrun), 32'd1);
    chk("ovr_x_hold", 32'(bus.x_out), 32'd612);
    chk("ovr_one_dac", 32'(bz), 32'd1);
`ifdef SAMPLE_SEQ_OVR_COUNT_EN
    chk("ovr_cnt_one", 32'(bus.ovr_cnt), 32'd1);
`endif
    bus.clr_ovr = 1'b1;
    step();
    bus.clr_ovr = 1'b0;
    chk("ovr_clear", 32'(bus.overrun), 32'd0);
`ifdef SAMPLE_SEQ_OVR_COUNT_EN
    chk("ovr_cnt_clear", 32'(bus.ovr_cnt), 32'd0);
`endif

    // run=0: edge ignored, no overrun
    bus.run = 1'b0;
    pulse_sample(10'd5, 8, pe_at, dl_at, bz);
    chk("norun_proc", 32'(pe_at), 32'hFFFF_FFFF);
    chk("norun_ovr", 32'(bus.overrun), 32'd0);

    // run dropped during PROCESS still completes
    bus.run = 1'b1;
    pulse_sample(10'd9, 3, pe_at, dl_at, bz);
    bus.run = 1'b0;
    steps(6, pe_n, dl_n);
    chk("rundrop_dac", 32'(dl_n), 32'd1);
    bus.run = 1'b1;

    // reset during PROCESS with data_valid held high
    bus.data_in    = 10'd300;
    bus.data_valid = 1'b1;
    steps(3, pe_n, dl_n);
    do_reset();
    steps(10, pe_n, dl_n);
    chk("rst_no_proc", 32'(pe_n), 32'd0);
    chk("rst_no_dac", 32'(dl_n), 32'd0);
    bus.data_valid = 1'b0;
    step();
    pulse_sample(10'd600, 8, pe_at, dl_at, bz);
    chk("rst_rearm", 32'(pe_at), 32'd1);

    // sample_cnt wrap from a preloaded value
    force u_dut.cnt_q = 16'hFFFD;
    m_cnt = 16'hFFFD;
    step();
    release u_dut.cnt_q;
    step();
    pulse_sample(10'd1, 8, pe_at, dl_at, bz);
    pulse_sample(10'd2, 8, pe_at, dl_at, bz);
    chk("cnt_ffff", 32'(bus.sample_cnt), 32'hFFFF);
    pulse_sample(10'd3, 8, pe_at, dl_at, bz);
    chk("cnt_wrap", 32'(bus.sample_cnt), 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) bus.data_valid = ~bus.data_valid;
      bus.run     = ($urandom_range(0, 7) != 0);
      bus.clr_ovr = ($urandom_range(0, 15) == 0);
      bus.data_in = 10'($urandom);
      if ($urandom_range(0, 799) == 0) do_reset();
      else step();
    end
    bus.clr_ovr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
